// File: rtl/fetch_prefetch_buffer_if.sv
// rtl/fetch_prefetch_buffer_if.sv - redirect, memory request/response and IFU handshake bundle
interface fetch_prefetch_buffer_if;
  logic        CTRL_i_redirect;
  logic [31:0] CTRL_i_redirect_pc;
  logic        MEM_o_req_valid;
  logic        MEM_i_req_ready;
  logic [31:0] MEM_o_req_addr;
  logic        MEM_i_resp_valid;
  logic [31:0] MEM_i_resp_data;
  logic        IFU_o_valid;
  logic        IFU_i_ready;
  logic [31:0] IFU_o_instr;
  logic [31:0] IFU_o_pc;

  modport master (
    output CTRL_i_redirect, CTRL_i_redirect_pc, MEM_i_req_ready,
           MEM_i_resp_valid, MEM_i_resp_data, IFU_i_ready,
    input  MEM_o_req_valid, MEM_o_req_addr, IFU_o_valid, IFU_o_instr, IFU_o_pc
  );

  modport slave (
    input  CTRL_i_redirect, CTRL_i_redirect_pc, MEM_i_req_ready,
           MEM_i_resp_valid, MEM_i_resp_data, IFU_i_ready,
    output MEM_o_req_valid, MEM_o_req_addr, IFU_o_valid, IFU_o_instr, IFU_o_pc
  );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// rtl/fetch_prefetch_buffer.sv - sequential instruction prefetcher with DEPTH-entry queue and redirect flush
// Optional same-cycle response-to-IFU bypass: define FETCH_PREFETCH_BYPASS_EN.
module fetch_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic                    clk,
  input logic                    rst,
  fetch_prefetch_buffer_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_run;
  logic [31:0]   r_fifo_pc    [DEPTH];
  logic [31:0]   r_fifo_instr [DEPTH];

  logic          w_redirect;
  logic [CW:0]   w_total;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_resp_kept;
  logic          w_count_nz;
  logic          w_bypass;
  logic          w_ifu_valid;
  logic          w_push;
  logic          w_pop;

  // r_run holds the request port quiet until the first edge after reset release.
  assign w_redirect  = bus.CTRL_i_redirect;
  assign w_total     = {1'b0, r_count} + {1'b0, r_inflight} + {1'b0, r_drop};
  assign w_req_valid = r_run && !w_redirect && (w_total < DEPTH_W);
  assign w_req_fire  = w_req_valid && bus.MEM_i_req_ready;
  assign w_resp_kept = bus.MEM_i_resp_valid && (r_drop == '0) && !w_redirect;
  assign w_count_nz  = (r_count != '0);

`ifdef FETCH_PREFETCH_BYPASS_EN
  assign w_bypass = r_run && !w_count_nz && w_resp_kept;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_ifu_valid = (w_count_nz || w_bypass) && !w_redirect;
  assign w_pop       = w_ifu_valid && bus.IFU_i_ready && w_count_nz;
  assign w_push      = w_resp_kept && !(w_bypass && bus.IFU_i_ready);

  assign bus.MEM_o_req_valid = w_req_valid;
  assign bus.MEM_o_req_addr  = r_run ? r_fetch_pc : '0;
  assign bus.IFU_o_valid     = w_ifu_valid;

  always_comb begin
    bus.IFU_o_pc    = '0;
    bus.IFU_o_instr = '0;
    if (w_ifu_valid && w_count_nz) begin
      bus.IFU_o_pc    = r_fifo_pc[r_rd_ptr];
      bus.IFU_o_instr = r_fifo_instr[r_rd_ptr];
    end
`ifdef FETCH_PREFETCH_BYPASS_EN
    else if (w_ifu_valid) begin
      bus.IFU_o_pc    = r_resp_pc;
      bus.IFU_o_instr = bus.MEM_i_resp_data;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_redirect) begin
        // Everything still owed by memory becomes stale, less the response landing now.
        r_fetch_pc <= bus.CTRL_i_redirect_pc;
        r_resp_pc  <= bus.CTRL_i_redirect_pc;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_drop     <= r_drop + r_inflight - CW'(bus.MEM_i_resp_valid);
        r_inflight <= '0;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (bus.MEM_i_resp_valid) begin
          if (r_drop != '0) begin
            r_drop <= r_drop - CW'(1);
          end else begin
            r_resp_pc <= r_resp_pc + 32'd4;
          end
        end
        r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_resp_kept);
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
      r_fifo_instr[r_wr_ptr] <= bus.MEM_i_resp_data;
    end
  end

  a_push_room: assert property (@(posedge clk) disable iff (rst) w_push |-> (r_count < CW'(DEPTH)));
  a_owed_cap:  assert property (@(posedge clk) disable iff (rst)
                                ({1'b0, r_inflight} + {1'b0, r_drop}) <= DEPTH_W);
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb/tb_fetch_prefetch_buffer.sv - randomized bench with a queue-level model of fetch_prefetch_buffer
`timescale 1ns/1ps
module tb_fetch_prefetch_buffer;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          ep;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_prefetch_buffer_if bus();

  fetch_prefetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Memory side: every accepted request, tagged with the redirect epoch it was issued in.
  req_t        memq[$];
  ent_t        expq[$];
  logic [31:0] fetch_pc;
  int          epoch;
  int          cyc;
  int          n_checks;
  int          n_fail;
  int          pr_req, pr_ifu, pr_resp, pr_redir, max_lat;
  bit          force_redir;
  logic [31:0] force_pc;
  logic [31:0] obs_pc[$];
  logic [31:0] acc_addr[$];
  int          n_valid;

  int tab_req   [4] = '{70, 100, 40, 90};
  int tab_ifu   [4] = '{70, 30, 100, 50};
  int tab_resp  [4] = '{60, 100, 50, 80};
  int tab_redir [4] = '{3, 1, 6, 2};
  int tab_lat   [4] = '{3, 0, 5, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle();
    bit   bypass_on;
    bit   exp_req;
    bit   exp_ifu;
    ent_t head;
    req_t r;
    @(posedge clk);
    #1;
    cyc++;
    bus.CTRL_i_redirect = force_redir || (int'($urandom_range(99)) < pr_redir);
    if (force_redir)                bus.CTRL_i_redirect_pc = force_pc;
    else if ($urandom_range(7) == 0) bus.CTRL_i_redirect_pc = 32'hFFFF_FFF8;
    else                            bus.CTRL_i_redirect_pc = $urandom & 32'hFFFF_FFFC;
    force_redir = 1'b0;
    bus.MEM_i_req_ready  = int'($urandom_range(99)) < pr_req;
    bus.IFU_i_ready      = int'($urandom_range(99)) < pr_ifu;
    bus.MEM_i_resp_valid = (memq.size() > 0) && (memq[0].due <= cyc) && (int'($urandom_range(99)) < pr_resp);
    bus.MEM_i_resp_data  = bus.MEM_i_resp_valid ? memq[0].data : $urandom;

    @(negedge clk);
    exp_req   = !bus.CTRL_i_redirect && (expq.size() + memq.size() < DEPTH);
    bypass_on = 1'b0;
`ifdef FETCH_PREFETCH_BYPASS_EN
    bypass_on = (expq.size() == 0) && bus.MEM_i_resp_valid && !bus.CTRL_i_redirect && (memq[0].ep == epoch);
`endif
    exp_ifu = !bus.CTRL_i_redirect && ((expq.size() > 0) || bypass_on);
    head    = '{32'h0, 32'h0};
    if (expq.size() > 0) head = expq[0];
    else if (bypass_on)  head = '{memq[0].addr, bus.MEM_i_resp_data};

    chk("req_valid", 32'(bus.MEM_o_req_valid), 32'(exp_req));
    if (exp_req) chk("req_addr", bus.MEM_o_req_addr, fetch_pc);
    chk("ifu_valid", 32'(bus.IFU_o_valid), 32'(exp_ifu));
    if (exp_ifu) begin
      chk("ifu_pc", bus.IFU_o_pc, head.pc);
      chk("ifu_instr", bus.IFU_o_instr, head.instr);
    end

    if (bus.MEM_o_req_valid && bus.MEM_i_req_ready) acc_addr.push_back(bus.MEM_o_req_addr);
    if (bus.IFU_o_valid) n_valid++;
    if (bus.IFU_o_valid && bus.IFU_i_ready) obs_pc.push_back(bus.IFU_o_pc);

    // Advance the model to the state after the coming edge.
    if (bus.CTRL_i_redirect) begin
      if (bus.MEM_i_resp_valid) void'(memq.pop_front());
      expq.delete();
      epoch++;
      fetch_pc = bus.CTRL_i_redirect_pc;
    end else begin
      if (exp_ifu && bus.IFU_i_ready && !bypass_on) void'(expq.pop_front());
      if (bus.MEM_i_resp_valid) begin
        r = memq.pop_front();
        if ((r.ep == epoch) && !(bypass_on && bus.IFU_i_ready))
          expq.push_back('{r.addr, bus.MEM_i_resp_data});
      end
      if (exp_req && bus.MEM_i_req_ready) begin
        memq.push_back('{fetch_pc, $urandom, epoch, cyc + 1 + int'($urandom_range(max_lat))});
        fetch_pc = fetch_pc + 32'd4;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_knobs(input int rq, input int fi, input int rs, input int rd, input int lt);
    pr_req = rq; pr_ifu = fi; pr_resp = rs; pr_redir = rd; max_lat = lt;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    force_redir = 1'b1;
    force_pc    = pc;
    cycle();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; epoch = 0; n_valid = 0;
    fetch_pc = RESET_PC; force_redir = 1'b0; force_pc = '0;
    bus.CTRL_i_redirect = 1'b0; bus.CTRL_i_redirect_pc = '0;
    bus.MEM_i_req_ready = 1'b0; bus.MEM_i_resp_valid = 1'b0;
    bus.MEM_i_resp_data = '0;   bus.IFU_i_ready = 1'b0;
    set_knobs(0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(bus.MEM_o_req_valid), 32'd0);
    chk("rst_req_addr", bus.MEM_o_req_addr, 32'd0);
    chk("rst_ifu_valid", 32'(bus.IFU_o_valid), 32'd0);
    chk("rst_ifu_pc", bus.IFU_o_pc, 32'd0);
    rst = 1'b0;
    #1;
    chk("release_req_valid", 32'(bus.MEM_o_req_valid), 32'd0);
    @(negedge clk);
    chk("first_req_valid", 32'(bus.MEM_o_req_valid), 32'd1);
    chk("first_req_addr", bus.MEM_o_req_addr, 32'h8000_0000);

    // IFU stalled: the queue fills to DEPTH and fetch stops.
    set_knobs(100, 0, 100, 0, 0);
    run(12);
    chk("full_accepted", 32'(acc_addr.size()), 32'd4);
    if (acc_addr.size() > 3) chk("full_last_addr", acc_addr[3], 32'h8000_000C);

    set_knobs(100, 100, 100, 0, 0);
    obs_pc.delete();
    run(6);
    n_valid = 0;
    run(6);
    chk("sustained_valid", 32'(n_valid), 32'd6);
    for (int i = 0; i < 4; i++)
      if (obs_pc.size() > i) chk("drain_pc", obs_pc[i], 32'h8000_0000 + 32'(4 * i));
    if (acc_addr.size() > 4) chk("resume_addr", acc_addr[4], 32'h8000_0010);

    // Memory stall, then redirect while stalled.
    set_knobs(0, 100, 100, 0, 0);
    run(5);
    redirect_to(32'h0000_0040);
    acc_addr.delete();
    set_knobs(100, 100, 100, 0, 0);
    cycle();
    chk("stall_redirect_count", 32'(acc_addr.size()), 32'd1);
    if (acc_addr.size() > 0) chk("stall_redirect_addr", acc_addr[0], 32'h0000_0040);

    // Three in flight, redirect to 0x100.
    set_knobs(0, 100, 100, 0, 0);
    run(8);
    set_knobs(100, 100, 0, 0, 0);
    run(3);
    redirect_to(32'h0000_0100);
    obs_pc.delete();
    set_knobs(100, 100, 100, 0, 0);
    run(10);
    chk("redir_delivered", 32'(obs_pc.size() > 1), 32'd1);
    if (obs_pc.size() > 1) begin
      chk("redir_first_pc", obs_pc[0], 32'h0000_0100);
      chk("redir_second_pc", obs_pc[1], 32'h0000_0104);
    end

    // Back-to-back redirects with two in flight.
    set_knobs(0, 100, 100, 0, 0);
    run(8);
    set_knobs(100, 100, 0, 0, 0);
    run(2);
    redirect_to(32'h0000_0200);
    redirect_to(32'h0000_0300);
    obs_pc.delete();
    set_knobs(100, 100, 100, 0, 0);
    run(10);
    chk("b2b_delivered", 32'(obs_pc.size() > 0), 32'd1);
    if (obs_pc.size() > 0) chk("b2b_first_pc", obs_pc[0], 32'h0000_0300);

    for (int p = 0; p < 4; p++) begin
      set_knobs(tab_req[p], tab_ifu[p], tab_resp[p], tab_redir[p], tab_lat[p]);
      run(2000);
    end

    // Asynchronous reset between edges.
    set_knobs(100, 50, 100, 0, 1);
    run(10);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_req_valid", 32'(bus.MEM_o_req_valid), 32'd0);
    chk("async_req_addr", bus.MEM_o_req_addr, 32'd0);
    chk("async_ifu_valid", 32'(bus.IFU_o_valid), 32'd0);
    chk("async_ifu_pc", bus.IFU_o_pc, 32'd0);
    chk("async_ifu_instr", bus.IFU_o_instr, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
